// File: rtl/nvdla_cvif_wr_wrr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nvdla_cvif_wr_wrr_arb_pkg
// Description : Shared constants, client indices, FSM state type and helpers
//               for the CVIF write-ingress weighted round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package nvdla_cvif_wr_wrr_arb_pkg;

    // Client indices in the request/grant vectors
    localparam int c_SDP  = 0;
    localparam int c_CDP  = 1;
    localparam int c_PDP  = 2;
    localparam int c_BDMA = 3;
    localparam int c_RBK  = 4;

    localparam int c_NUM_CLIENTS = 5;
    localparam int c_LEN_W       = 2;   // beats-1 per request
    localparam int c_OS_W        = 9;   // outstanding-beat counter, holds 256 plus margin

    typedef enum logic [1:0] {
        ARB = 2'd0,
        CMD = 2'd1,
        DAT = 2'd2
    } wr_arb_state_e;

    // A programmed weight of zero still grants once per round
    function automatic logic [7:0] eff_weight(input logic [7:0] w);
        return (w == 8'd0) ? 8'd1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nvdla_cvif_wr_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : nvdla_cvif_wr_rr_pick
// Description : Combinational masked round-robin picker. Chooses the first
//               set bit of the eligible vector strictly above the pointer,
//               wrapping to the lowest set bit when none lies above it.
// Revision    : 1.0 - initial release
// ============================================================================
module nvdla_cvif_wr_rr_pick #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     i_elig,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt_oh,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_any
);

    logic [N-1:0] w_mask;
    logic [N-1:0] w_hi;
    logic [N-1:0] w_src;
    logic         w_found;

    // Mask off everything at or below the pointer, fall back to the full vector
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (i > int'(i_ptr));
        end
        w_hi  = i_elig & w_mask;
        w_src = (|w_hi) ? w_hi : i_elig;
    end

    // Lowest set bit of the selected source vector wins
    always_comb begin
        o_gnt_oh  = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_src[i] && !w_found) begin
                o_gnt_oh[i] = 1'b1;
                o_gnt_idx   = IDX_W'(i);
                w_found     = 1'b1;
            end
        end
    end

    assign o_any = |i_elig;

endmodule
`default_nettype wire

// File: rtl/nvdla_cvif_wr_wrr_arb.sv
`default_nettype none
// ============================================================================
// Module      : nvdla_cvif_wr_wrr_arb
// Description : Weighted round-robin scheduler sharing the CVIF AXI AW/W path
//               among five write clients. Locks the path for command plus all
//               data beats and throttles issue against an outstanding-beat
//               budget replenished by write-response returns.
// Revision    : 1.0 - initial release
// ============================================================================
module nvdla_cvif_wr_wrr_arb
    import nvdla_cvif_wr_wrr_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = c_NUM_CLIENTS,
    parameter int LEN_W       = c_LEN_W,
    parameter int OS_W        = c_OS_W
) (
    input  logic                       nvdla_core_clk,
    input  logic                       nvdla_core_rstn,
    input  logic [NUM_CLIENTS-1:0]       req_vld,
    input  logic [NUM_CLIENTS*LEN_W-1:0] req_len,
    output logic [NUM_CLIENTS-1:0]       req_rdy,
    output logic                       gnt_vld,
    input  logic                       gnt_rdy,
    output logic [2:0]                 gnt_id,
    output logic [LEN_W-1:0]           gnt_len,
    input  logic                       dat_acc,
    input  logic                       eg2ig_axi_vld,
    input  logic [LEN_W-1:0]           eg2ig_axi_len,
    input  logic [7:0]                 reg2dp_wr_os_cnt,
    input  logic [7:0]                 reg2dp_wr_weight_sdp,
    input  logic [7:0]                 reg2dp_wr_weight_cdp,
    input  logic [7:0]                 reg2dp_wr_weight_pdp,
    input  logic [7:0]                 reg2dp_wr_weight_bdma,
    input  logic [7:0]                 reg2dp_wr_weight_rbk,
    output logic [OS_W-1:0]            os_cnt,
    output logic                       os_err
);

    localparam logic [OS_W:0] c_ONE = (OS_W+1)'(1);

    wr_arb_state_e          r_state;
    logic                   r_gnt_vld;
    logic [2:0]             r_gnt_id;
    logic [LEN_W-1:0]       r_gnt_len;
    logic [LEN_W-1:0]       r_beat;
    logic [2:0]             r_ptr;
    logic [7:0]             r_wcnt [NUM_CLIENTS];
    logic [OS_W-1:0]        r_os_cnt;
    logic                   r_os_err;

    logic [7:0]             w_weight [NUM_CLIENTS];
    logic [LEN_W-1:0]       w_len    [NUM_CLIENTS];
    logic [NUM_CLIENTS-1:0] w_fit;
    logic [NUM_CLIENTS-1:0] w_wnz;
    logic [NUM_CLIENTS-1:0] w_cand;
    logic [NUM_CLIENTS-1:0] w_elig_norm;
    logic [NUM_CLIENTS-1:0] w_elig;
    logic                   w_reload;
    logic [NUM_CLIENTS-1:0] w_pick_oh;
    logic [2:0]             w_pick_idx;
    logic                   w_pick_any;
    logic                   w_cmd_acc;
    logic [OS_W:0]          w_limit;
    logic [OS_W:0]          w_inc;
    logic [OS_W:0]          w_dec;
    logic [OS_W:0]          w_sum;

    // Gather the named weight registers and per-client lengths into arrays
    always_comb begin
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            w_weight[i] = 8'd1;
            w_len[i]    = req_len[i*LEN_W +: LEN_W];
        end
        w_weight[c_SDP]  = reg2dp_wr_weight_sdp;
        w_weight[c_CDP]  = reg2dp_wr_weight_cdp;
        w_weight[c_PDP]  = reg2dp_wr_weight_pdp;
        w_weight[c_BDMA] = reg2dp_wr_weight_bdma;
        w_weight[c_RBK]  = reg2dp_wr_weight_rbk;
    end

    // Eligibility: pending, fits in the outstanding budget, credit left.
    // When every fitting requester is out of credit, reload and arbitrate
    // on the reloaded credits in the same cycle.
    always_comb begin
        w_limit = (OS_W+1)'(reg2dp_wr_os_cnt) + c_ONE;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            w_fit[i] = ({1'b0, r_os_cnt} + (OS_W+1)'(w_len[i]) + c_ONE) <= w_limit;
            w_wnz[i] = (r_wcnt[i] != 8'd0);
        end
        w_cand      = req_vld & w_fit;
        w_elig_norm = w_cand & w_wnz;
        w_reload    = (r_state == ARB) && (w_elig_norm == '0) && (|(w_cand & ~w_wnz));
        w_elig      = w_reload ? w_cand : w_elig_norm;
    end

    nvdla_cvif_wr_rr_pick #(
        .N     (NUM_CLIENTS),
        .IDX_W (3)
    ) u_pick (
        .i_elig    (w_elig),
        .i_ptr     (r_ptr),
        .o_gnt_oh  (w_pick_oh),
        .o_gnt_idx (w_pick_idx),
        .o_any     (w_pick_any)
    );

    assign w_cmd_acc = (r_state == CMD) && gnt_rdy;

    // One-hot acknowledge to the requester in the command-accept cycle
    always_comb begin
        req_rdy = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            req_rdy[i] = w_cmd_acc && (r_gnt_id == 3'(i));
        end
    end

    // Arbitration FSM: ARB picks, CMD holds the command, DAT counts beats
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_state   <= ARB;
            r_gnt_vld <= 1'b0;
            r_gnt_id  <= 3'd0;
            r_gnt_len <= '0;
            r_beat    <= '0;
            r_ptr     <= 3'd4;
            for (int i = 0; i < NUM_CLIENTS; i++) begin
                r_wcnt[i] <= 8'd0;
            end
        end else begin
            case (r_state)
                ARB: begin
                    for (int i = 0; i < NUM_CLIENTS; i++) begin
                        if (w_pick_any && w_pick_oh[i]) begin
                            r_wcnt[i] <= (w_reload ? eff_weight(w_weight[i]) : r_wcnt[i]) - 8'd1;
                        end else if (w_reload) begin
                            r_wcnt[i] <= eff_weight(w_weight[i]);
                        end
                    end
                    if (w_pick_any) begin
                        r_gnt_id  <= w_pick_idx;
                        r_gnt_len <= w_len[w_pick_idx];
                        r_gnt_vld <= 1'b1;
                        r_ptr     <= w_pick_idx;
                        r_state   <= CMD;
                    end
                end
                CMD: begin
                    if (gnt_rdy) begin
                        r_gnt_vld <= 1'b0;
                        r_beat    <= r_gnt_len;
                        r_state   <= DAT;
                    end
                end
                DAT: begin
                    if (dat_acc) begin
                        if (r_beat == '0) begin
                            r_state <= ARB;
                        end else begin
                            r_beat <= r_beat - 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= ARB;
                    r_gnt_vld <= 1'b0;
                end
            endcase
        end
    end

    // Outstanding-beat accounting with saturating underflow
    always_comb begin
        w_inc = w_cmd_acc     ? ((OS_W+1)'(r_gnt_len) + c_ONE)     : '0;
        w_dec = eg2ig_axi_vld ? ((OS_W+1)'(eg2ig_axi_len) + c_ONE) : '0;
        w_sum = {1'b0, r_os_cnt} + w_inc;
    end

    // Apply increment and decrement together; underflow clamps and sticks
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_os_cnt <= '0;
            r_os_err <= 1'b0;
        end else begin
            if (w_dec > w_sum) begin
                r_os_cnt <= '0;
                r_os_err <= 1'b1;
            end else begin
                r_os_cnt <= OS_W'(w_sum - w_dec);
            end
        end
    end

    assign gnt_vld = r_gnt_vld;
    assign gnt_id  = r_gnt_id;
    assign gnt_len = r_gnt_len;
    assign os_cnt  = r_os_cnt;
    assign os_err  = r_os_err;

endmodule
`default_nettype wire

// File: tb/tb_nvdla_cvif_wr_wrr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_nvdla_cvif_wr_wrr_arb
// Description : Directed self-checking bench for the CVIF write WRR arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nvdla_cvif_wr_wrr_arb;

    logic       clk;
    logic       rstn;
    logic [4:0] req_vld;
    logic [9:0] req_len;
    logic [4:0] req_rdy;
    logic       gnt_vld;
    logic       gnt_rdy;
    logic [2:0] gnt_id;
    logic [1:0] gnt_len;
    logic       dat_acc;
    logic       eg_vld;
    logic [1:0] eg_len;
    logic [7:0] budget;
    logic [7:0] w_sdp, w_cdp, w_pdp, w_bdma, w_rbk;
    logic [8:0] os_cnt;
    logic       os_err;

    int n_checks = 0;
    int n_errors = 0;

    nvdla_cvif_wr_wrr_arb dut (
        .nvdla_core_clk        (clk),
        .nvdla_core_rstn       (rstn),
        .req_vld               (req_vld),
        .req_len               (req_len),
        .req_rdy               (req_rdy),
        .gnt_vld               (gnt_vld),
        .gnt_rdy               (gnt_rdy),
        .gnt_id                (gnt_id),
        .gnt_len               (gnt_len),
        .dat_acc               (dat_acc),
        .eg2ig_axi_vld         (eg_vld),
        .eg2ig_axi_len         (eg_len),
        .reg2dp_wr_os_cnt      (budget),
        .reg2dp_wr_weight_sdp  (w_sdp),
        .reg2dp_wr_weight_cdp  (w_cdp),
        .reg2dp_wr_weight_pdp  (w_pdp),
        .reg2dp_wr_weight_bdma (w_bdma),
        .reg2dp_wr_weight_rbk  (w_rbk),
        .os_cnt                (os_cnt),
        .os_err                (os_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic apply_reset();
        req_vld = '0; req_len = '0; gnt_rdy = 1'b0; dat_acc = 1'b0;
        eg_vld = 1'b0; eg_len = '0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Wait at negedges for gnt_vld, bounded
    task automatic wait_gnt();
        for (int i = 0; i < 50 && !gnt_vld; i++) @(negedge clk);
        if (!gnt_vld) check("gnt_timeout", 32'd0, 32'd1);
    endtask

    // One full request from client c, optional response in the accept cycle
    task automatic do_req(input int c, input logic [1:0] len, input logic rv, input logic [1:0] rl);
        req_len[c*2 +: 2] = len;
        req_vld = 5'(1 << c);
        gnt_rdy = 1'b0;
        dat_acc = 1'b0;
        wait_gnt();
        req_vld = '0;
        check("req_id", 32'(gnt_id), 32'(c));
        check("req_len", 32'(gnt_len), 32'(len));
        gnt_rdy = 1'b1;
        eg_vld  = rv;
        eg_len  = rl;
        #1 check("req_rdy_pulse", 32'(req_rdy), 32'(1 << c));
        @(negedge clk);
        gnt_rdy = 1'b0;
        eg_vld  = 1'b0;
        dat_acc = 1'b1;
        repeat (int'(len) + 1) @(negedge clk);
        dat_acc = 1'b0;
    endtask

    int exp_seq [14] = '{0, 1, 2, 3, 4, 0, 0, 1, 2, 3, 4, 0, 0, 0};
    int got_seq [14];
    int at_cyc  [14];
    int n_got;

    initial begin
        rstn = 1'b0;
        budget = 8'd255;
        w_sdp = 8'd3; w_cdp = 8'd1; w_pdp = 8'd1; w_bdma = 8'd1; w_rbk = 8'd1;
        apply_reset();

        // Reset state
        check("rst_gnt_vld", 32'(gnt_vld), 32'd0);
        check("rst_gnt_id",  32'(gnt_id),  32'd0);
        check("rst_gnt_len", 32'(gnt_len), 32'd0);
        check("rst_req_rdy", 32'(req_rdy), 32'd0);
        check("rst_os_cnt",  32'(os_cnt),  32'd0);
        check("rst_os_err",  32'(os_err),  32'd0);

        // WRR order with sdp weight 3, everything tied ready
        req_vld = 5'b11111; req_len = '0; gnt_rdy = 1'b1; dat_acc = 1'b1;
        n_got = 0;
        for (int cyc = 0; cyc < 200 && n_got < 14; cyc++) begin
            @(negedge clk);
            if (gnt_vld && gnt_rdy) begin
                got_seq[n_got] = int'(gnt_id);
                at_cyc[n_got]  = cyc;
                n_got++;
            end
        end
        req_vld = '0;
        check("wrr_count", 32'(n_got), 32'd14);
        for (int i = 0; i < n_got; i++) check($sformatf("wrr_order[%0d]", i), 32'(got_seq[i]), 32'(exp_seq[i]));
        if (n_got >= 2) check("wrr_spacing", 32'(at_cyc[1] - at_cyc[0]), 32'd3);
        repeat (4) @(negedge clk);
        check("wrr_os_cnt", 32'(os_cnt), 32'd14);

        // Budget throttling: limit 4 beats
        apply_reset();
        budget = 8'd3;
        do_req(0, 2'd3, 1'b0, 2'd0);
        check("bud_os_cnt", 32'(os_cnt), 32'd4);
        req_len[1:0] = 2'd3; req_vld = 5'b00001;
        repeat (5) @(negedge clk);
        check("bud_stall", 32'(gnt_vld), 32'd0);
        eg_vld = 1'b1; eg_len = 2'd3;
        @(negedge clk);
        eg_vld = 1'b0;
        check("bud_drained", 32'(os_cnt), 32'd0);
        @(negedge clk);
        check("bud_regrant_vld", 32'(gnt_vld), 32'd1);
        check("bud_regrant_id",  32'(gnt_id),  32'd0);

        // Simultaneous inc (+2) and dec (-1) from os_cnt=5
        apply_reset();
        budget = 8'd255;
        do_req(0, 2'd3, 1'b0, 2'd0);
        do_req(1, 2'd0, 1'b0, 2'd0);
        check("sim_pre_os", 32'(os_cnt), 32'd5);
        do_req(2, 2'd1, 1'b1, 2'd0);
        check("sim_os_cnt", 32'(os_cnt), 32'd6);

        // Underflow saturates and sets the sticky error
        apply_reset();
        do_req(3, 2'd0, 1'b0, 2'd0);
        check("uf_pre_os",  32'(os_cnt), 32'd1);
        check("uf_pre_err", 32'(os_err), 32'd0);
        eg_vld = 1'b1; eg_len = 2'd3;
        @(negedge clk);
        eg_vld = 1'b0;
        check("uf_os_cnt", 32'(os_cnt), 32'd0);
        check("uf_err",    32'(os_err), 32'd1);
        repeat (5) @(negedge clk);
        check("uf_err_sticky", 32'(os_err), 32'd1);

        // Command held stable while gnt_rdy low and the request drops
        apply_reset();
        req_len[5:4] = 2'd2; req_vld = 5'b00100; gnt_rdy = 1'b0;
        wait_gnt();
        req_vld = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("hold_cmd[%0d]", i), {26'd0, gnt_vld, gnt_id, gnt_len}, {26'd0, 1'b1, 3'd2, 2'd2});
        end
        check("hold_no_rdy", 32'(req_rdy), 32'd0);
        gnt_rdy = 1'b1;
        #1 check("hold_rdy_pulse", 32'(req_rdy), 32'b00100);
        @(negedge clk);
        check("hold_rdy_end", 32'(req_rdy), 32'd0);
        check("hold_vld_end", 32'(gnt_vld), 32'd0);
        gnt_rdy = 1'b0;

        // Asynchronous reset in DAT with two beats still pending
        apply_reset();
        req_len[7:6] = 2'd2; req_vld = 5'b01000;
        wait_gnt();
        req_vld = '0;
        gnt_rdy = 1'b1;
        @(negedge clk);
        gnt_rdy = 1'b0; dat_acc = 1'b1;
        @(negedge clk);
        dat_acc = 1'b0;
        check("ar_pre_os", 32'(os_cnt), 32'd3);
        rstn = 1'b0;
        #1;
        check("ar_gnt_vld", 32'(gnt_vld), 32'd0);
        check("ar_gnt_id",  32'(gnt_id),  32'd0);
        check("ar_gnt_len", 32'(gnt_len), 32'd0);
        check("ar_req_rdy", 32'(req_rdy), 32'd0);
        check("ar_os_cnt",  32'(os_cnt),  32'd0);
        check("ar_os_err",  32'(os_err),  32'd0);
        req_vld = 5'b11111; req_len = '0;
        @(negedge clk);
        rstn = 1'b1;
        wait_gnt();
        check("ar_first_id", 32'(gnt_id), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
